// File: rtl/xm23_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : xm23_pkg
//  Brief    : Shared fetch-unit constants and FSM state encoding.
//  Revision : 1.0
// ============================================================================
package xm23_pkg;

    localparam logic [15:0] c_FETCH_STEP      = 16'd2;
    localparam int          c_MEM_TIMEOUT_DEF = 15;
    localparam int          c_TIMER_W         = 8;

    localparam logic [1:0]  c_ST_IDLE = 2'd0;
    localparam logic [1:0]  c_ST_REQ  = 2'd1;
    localparam logic [1:0]  c_ST_WAIT = 2'd2;
    localparam logic [1:0]  c_ST_HOLD = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE = c_ST_IDLE,
        ST_REQ  = c_ST_REQ,
        ST_WAIT = c_ST_WAIT,
        ST_HOLD = c_ST_HOLD
    } fetch_state_t;

endpackage
`default_nettype wire

// File: rtl/fetch_timer.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_timer
//  Brief    : Wait-state counter; expired flags the final allowed WAIT cycle.
//  Revision : 1.0
// ============================================================================
module fetch_timer
    import xm23_pkg::*;
#(
    parameter int LIMIT = c_MEM_TIMEOUT_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam logic [c_TIMER_W-1:0] c_LAST = c_TIMER_W'(LIMIT - 1);

    logic [c_TIMER_W-1:0] r_count;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            r_count <= '0;
        end else if (enable && !expired) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign expired = (r_count == c_LAST);

endmodule
`default_nettype wire

// File: rtl/instr_fetch.sv
`default_nettype none
// ============================================================================
//  Module   : instr_fetch
//  Brief    : Instruction fetch FSM with breakpoint, odd-PC and bus-timeout faults.
//  Revision : 1.0
// ============================================================================
module instr_fetch #(
    parameter int   MEM_TIMEOUT = xm23_pkg::c_MEM_TIMEOUT_DEF,
    parameter logic BKPT_EN     = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] pc_in,
    input  logic        sleep,
    input  logic [15:0] bkpnt,
    output logic [15:0] mem_addr,
    output logic        mem_rd,
    input  logic [15:0] mem_rdata,
    input  logic        mem_ack,
    output logic [15:0] ir_out,
    output logic        ir_valid,
    input  logic        ir_ready,
    output logic [15:0] pc_next,
    output logic        pc_we,
    output logic        bkpt_hit,
    output logic        fault_odd,
    output logic        fault_bus,
    output logic        busy
);

    import xm23_pkg::*;

    fetch_state_t r_state;
    fetch_state_t w_state_nxt;

    logic [15:0] r_pc;
    logic [15:0] r_ir;
    logic [15:0] r_pc_next;
    logic        r_pc_we;
    logic        r_bkpt_hit;
    logic        r_fault_odd;
    logic        r_fault_bus;

    logic        w_start_ok;
    logic        w_bkpt_ev;
    logic        w_odd_ev;
    logic        w_ack_take;
    logic        w_timeout;
    logic        w_timer_expired;
    logic        w_is_bkpt;

    assign w_is_bkpt = (BKPT_EN == 1'b1) && (pc_in == bkpnt);

    always_comb begin
        w_state_nxt = r_state;
        w_start_ok  = 1'b0;
        w_ack_take  = 1'b0;
        w_timeout   = 1'b0;
        case (r_state)
            ST_IDLE: w_start_ok = start && !sleep;
            ST_REQ:  w_state_nxt = ST_WAIT;
            ST_WAIT: begin
                if (mem_ack) begin
                    w_ack_take  = 1'b1;
                    w_state_nxt = ST_HOLD;
                end else if (w_timer_expired) begin
                    w_timeout   = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_HOLD: begin
                if (ir_ready) begin
                    w_start_ok  = start && !sleep;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
        // A rejected start (breakpoint or odd PC) leaves the FSM idle.
        if (w_start_ok) begin
            w_state_nxt = (w_is_bkpt || pc_in[0]) ? ST_IDLE : ST_REQ;
        end
    end

    assign w_bkpt_ev = w_start_ok && w_is_bkpt;
    assign w_odd_ev  = w_start_ok && !w_is_bkpt && pc_in[0];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc        <= 16'h0000;
            r_ir        <= 16'h0000;
            r_pc_next   <= 16'h0000;
            r_pc_we     <= 1'b0;
            r_bkpt_hit  <= 1'b0;
            r_fault_odd <= 1'b0;
            r_fault_bus <= 1'b0;
        end else begin
            r_pc_we     <= w_ack_take;
            r_bkpt_hit  <= w_bkpt_ev;
            r_fault_odd <= w_odd_ev;
            r_fault_bus <= w_timeout;
            if (w_start_ok) begin
                r_pc <= pc_in;
            end
            if (w_ack_take) begin
                r_ir      <= mem_rdata;
                r_pc_next <= r_pc + c_FETCH_STEP;
            end
        end
    end

    fetch_timer #(
        .LIMIT (MEM_TIMEOUT)
    ) u_fetch_timer (
        .clk     (clk),
        .rst     (rst),
        .clear   (r_state != ST_WAIT),
        .enable  (r_state == ST_WAIT),
        .expired (w_timer_expired)
    );

    assign mem_addr  = r_pc;
    assign mem_rd    = (r_state == ST_REQ);
    assign ir_out    = r_ir;
    assign ir_valid  = (r_state == ST_HOLD);
    assign pc_next   = r_pc_next;
    assign pc_we     = r_pc_we;
    assign bkpt_hit  = r_bkpt_hit;
    assign fault_odd = r_fault_odd;
    assign fault_bus = r_fault_bus;
    assign busy      = (r_state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch.sv
`default_nettype none
// ============================================================================
//  Module   : tb_instr_fetch
//  Brief    : Directed self-checking bench for instr_fetch.
//  Revision : 1.0
// ============================================================================
module tb_instr_fetch;

    logic        clk;
    logic        rst;
    logic        start;
    logic [15:0] pc_in;
    logic        sleep;
    logic [15:0] bkpnt;
    logic [15:0] mem_addr;
    logic        mem_rd;
    logic [15:0] mem_rdata;
    logic        mem_ack;
    logic [15:0] ir_out;
    logic        ir_valid;
    logic        ir_ready;
    logic [15:0] pc_next;
    logic        pc_we;
    logic        bkpt_hit;
    logic        fault_odd;
    logic        fault_bus;
    logic        busy;

    int checks = 0;
    int errors = 0;

    instr_fetch #(
        .MEM_TIMEOUT (15),
        .BKPT_EN     (1'b1)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .pc_in     (pc_in),
        .sleep     (sleep),
        .bkpnt     (bkpnt),
        .mem_addr  (mem_addr),
        .mem_rd    (mem_rd),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack),
        .ir_out    (ir_out),
        .ir_valid  (ir_valid),
        .ir_ready  (ir_ready),
        .pc_next   (pc_next),
        .pc_we     (pc_we),
        .bkpt_hit  (bkpt_hit),
        .fault_odd (fault_odd),
        .fault_bus (fault_bus),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Outputs are sampled and inputs changed 1ns after each rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Packed flag view: {mem_rd, ir_valid, pc_we, bkpt_hit, fault_odd, fault_bus, busy}
    function automatic logic [6:0] flags();
        return {mem_rd, ir_valid, pc_we, bkpt_hit, fault_odd, fault_bus, busy};
    endfunction

    task automatic test_reset();
        rst = 1'b1; mem_ack = 1'b1; mem_rdata = 16'hDEAD;
        tick(); tick();
        checks++;
        if ({mem_addr, ir_out, pc_next} !== 48'h0 || flags() !== 7'b0) begin
            errors++;
            $display("FAIL reset_state actual=%h/%h/%h flags=%b required=0/0/0 flags=0000000",
                     mem_addr, ir_out, pc_next, flags());
        end
        rst = 1'b0;
        tick();
        mem_ack = 1'b0;
        checks++;
        if (flags() !== 7'b0) begin
            errors++;
            $display("FAIL idle_ack_ignored actual=%b required=0000000", flags());
        end
    endtask

    task automatic test_basic_fetch();
        pc_in = 16'h0100; start = 1'b1;
        tick();
        start = 1'b0;
        checks++;
        if (flags() !== 7'b1000001 || mem_addr !== 16'h0100) begin
            errors++;
            $display("FAIL basic_req actual=%b/%h required=1000001/0100", flags(), mem_addr);
        end
        tick();
        checks++;
        if (flags() !== 7'b0000001 || mem_addr !== 16'h0100) begin
            errors++;
            $display("FAIL basic_wait actual=%b/%h required=0000001/0100", flags(), mem_addr);
        end
        mem_ack = 1'b1; mem_rdata = 16'h4C8A;
        tick();
        mem_ack = 1'b0; mem_rdata = 16'h0000;
        checks++;
        if (flags() !== 7'b0110001 || ir_out !== 16'h4C8A || pc_next !== 16'h0102) begin
            errors++;
            $display("FAIL basic_result actual=%b/%h/%h required=0110001/4c8a/0102",
                     flags(), ir_out, pc_next);
        end
        ir_ready = 1'b1;
        tick();
        ir_ready = 1'b0;
        checks++;
        if (flags() !== 7'b0 || ir_out !== 16'h4C8A) begin
            errors++;
            $display("FAIL basic_release actual=%b/%h required=0000000/4c8a", flags(), ir_out);
        end
    endtask

    task automatic test_bkpt_odd();
        bkpnt = 16'h00F6; pc_in = 16'h00F6; start = 1'b1;
        tick();
        start = 1'b0;
        checks++;
        if (flags() !== 7'b0001000) begin
            errors++;
            $display("FAIL bkpt_pulse actual=%b required=0001000", flags());
        end
        tick();
        checks++;
        if (flags() !== 7'b0) begin
            errors++;
            $display("FAIL bkpt_after actual=%b required=0000000", flags());
        end
        pc_in = 16'h0103; start = 1'b1;
        tick();
        start = 1'b0;
        checks++;
        if (flags() !== 7'b0000100) begin
            errors++;
            $display("FAIL odd_pulse actual=%b required=0000100", flags());
        end
        bkpnt = 16'h0103; start = 1'b1;
        tick();
        start = 1'b0;
        checks++;
        if (flags() !== 7'b0001000) begin
            errors++;
            $display("FAIL bkpt_over_odd actual=%b required=0001000", flags());
        end
        bkpnt = 16'hAAAA;
        tick();
    endtask

    task automatic test_timeout();
        pc_in = 16'h0200; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        for (int i = 1; i <= 14; i++) begin
            tick();
            checks++;
            if (fault_bus !== 1'b0 || busy !== 1'b1) begin
                errors++;
                $display("FAIL timeout_early cyc=%0d actual=%b%b required=01", i, fault_bus, busy);
            end
        end
        tick();
        checks++;
        if (flags() !== 7'b0000010 || ir_out !== 16'h4C8A || pc_next !== 16'h0102) begin
            errors++;
            $display("FAIL timeout_fault actual=%b/%h/%h required=0000010/4c8a/0102",
                     flags(), ir_out, pc_next);
        end
        tick();
        checks++;
        if (flags() !== 7'b0) begin
            errors++;
            $display("FAIL timeout_after actual=%b required=0000000", flags());
        end
    endtask

    task automatic test_back_to_back();
        pc_in = 16'hFFFE; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        mem_ack = 1'b1; mem_rdata = 16'h1234;
        tick();
        mem_ack = 1'b0; mem_rdata = 16'h0000;
        checks++;
        if (flags() !== 7'b0110001 || pc_next !== 16'h0000 || ir_out !== 16'h1234) begin
            errors++;
            $display("FAIL wrap_result actual=%b/%h/%h required=0110001/0000/1234",
                     flags(), pc_next, ir_out);
        end
        for (int i = 1; i <= 5; i++) begin
            start = (i == 2); pc_in = 16'h0300;
            tick();
            checks++;
            if (flags() !== 7'b0100001 || ir_out !== 16'h1234 || mem_addr !== 16'hFFFE) begin
                errors++;
                $display("FAIL hold_stable cyc=%0d actual=%b/%h/%h required=0100001/1234/fffe",
                         i, flags(), ir_out, mem_addr);
            end
        end
        ir_ready = 1'b1; start = 1'b1; pc_in = 16'h0000;
        tick();
        ir_ready = 1'b0; start = 1'b0;
        checks++;
        if (flags() !== 7'b1000001 || mem_addr !== 16'h0000) begin
            errors++;
            $display("FAIL b2b_req actual=%b/%h required=1000001/0000", flags(), mem_addr);
        end
        tick();
        mem_ack = 1'b1; mem_rdata = 16'hABCD;
        tick();
        mem_ack = 1'b0;
        checks++;
        if (flags() !== 7'b0110001 || ir_out !== 16'hABCD || pc_next !== 16'h0002) begin
            errors++;
            $display("FAIL b2b_result actual=%b/%h/%h required=0110001/abcd/0002",
                     flags(), ir_out, pc_next);
        end
        ir_ready = 1'b1;
        tick();
        ir_ready = 1'b0;
    endtask

    task automatic test_sleep_inflight();
        pc_in = 16'h0700; start = 1'b1;
        tick();
        start = 1'b0; sleep = 1'b1;
        tick();
        mem_ack = 1'b1; mem_rdata = 16'h7777;
        tick();
        mem_ack = 1'b0;
        checks++;
        if (flags() !== 7'b0110001 || ir_out !== 16'h7777 || pc_next !== 16'h0702) begin
            errors++;
            $display("FAIL sleep_inflight actual=%b/%h/%h required=0110001/7777/0702",
                     flags(), ir_out, pc_next);
        end
        sleep = 1'b0; ir_ready = 1'b1;
        tick();
        ir_ready = 1'b0;
    endtask

    task automatic test_reset_midfetch();
        pc_in = 16'h0400; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0; mem_ack = 1'b1; mem_rdata = 16'h5555;
        checks++;
        if ({mem_addr, ir_out, pc_next} !== 48'h0 || flags() !== 7'b0) begin
            errors++;
            $display("FAIL reset_wait actual=%h/%h/%h flags=%b required=0/0/0 flags=0000000",
                     mem_addr, ir_out, pc_next, flags());
        end
        tick();
        mem_ack = 1'b0;
        checks++;
        if (flags() !== 7'b0 || ir_out !== 16'h0000) begin
            errors++;
            $display("FAIL post_reset_ack actual=%b/%h required=0000000/0000", flags(), ir_out);
        end
        sleep = 1'b1; start = 1'b1; pc_in = 16'h0500;
        tick();
        start = 1'b0;
        tick();
        checks++;
        if (flags() !== 7'b0 || mem_addr !== 16'h0000) begin
            errors++;
            $display("FAIL sleep_block actual=%b/%h required=0000000/0000", flags(), mem_addr);
        end
        sleep = 1'b0; rst = 1'b1; start = 1'b1; pc_in = 16'h0600;
        tick();
        rst = 1'b0; start = 1'b0;
        tick();
        checks++;
        if (flags() !== 7'b0 || mem_addr !== 16'h0000) begin
            errors++;
            $display("FAIL reset_over_start actual=%b/%h required=0000000/0000", flags(), mem_addr);
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; pc_in = 16'h0000; sleep = 1'b0;
        bkpnt = 16'hAAAA; mem_rdata = 16'h0000; mem_ack = 1'b0; ir_ready = 1'b0;
        test_reset();
        test_basic_fetch();
        test_bkpt_odd();
        test_timeout();
        test_back_to_back();
        test_sleep_inflight();
        test_reset_midfetch();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameters SHALL be: MEM_TIMEOUT, 15, max WAIT cycles before bus fault (1..255); BKPT_EN, 1, enables breakpoint compare.
REQ-002 Clock  in  1  single system clock; all state changes on rising edge.
REQ-003 Reset  in  1  synchronous, active-high.
REQ-004 start  in  1  one-cycle request from control unit to fetch the instruction at pc_in.
REQ-005 pc_in  in  16  current PC (register file R7).
REQ-006 sleep  in  1  PSW SLP bit; 1 blocks new fetches.
REQ-007 bkpnt  in  16  breakpoint address.
REQ-008 mem_addr  out  16  word address to memory.
REQ-009 mem_rd  out  1  read strobe, one cycle per fetch.
REQ-010 mem_rdata  in  16  memory read data, valid with mem_ack.
REQ-011 mem_ack  in  1  memory read complete (arbitrary wait states).
REQ-012 ir_out  out  16  fetched instruction word for the IR/decoder.
REQ-013 ir_valid  out  1  ir_out valid; held until ir_ready.
REQ-014 ir_ready  in  1  decoder accepts ir_out.
REQ-015 pc_next  out  16  fetched PC + 2.
REQ-016 pc_we  out  1  one-cycle pulse: write pc_next to R7.
REQ-017 bkpt_hit, fault_odd, fault_bus  out  1 each  one-cycle event pulses.
REQ-018 busy  out  1  high whenever state is not IDLE.

Function
REQ-019 The FSM SHALL have states IDLE, REQ, WAIT, HOLD.
REQ-020 IDLE: start=1 with sleep=0 SHALL latch pc_in; start with sleep=1 SHALL be ignored with no outputs.
REQ-021 On an accepted start with BKPT_EN=1 and pc_in==bkpnt, the block SHALL pulse bkpt_hit next cycle, issue no read, and remain IDLE; breakpoint takes priority over the odd check.
REQ-022 On an accepted start with pc_in[0]=1, the block SHALL pulse fault_odd next cycle, issue no read, and remain IDLE.
REQ-023 Otherwise the FSM SHALL enter REQ: mem_rd=1 for exactly one cycle, mem_addr=latched PC.
REQ-024 REQ SHALL go to WAIT unconditionally; mem_ack is sampled only in WAIT, and mem_addr holds the latched PC through WAIT.
REQ-025 WAIT with mem_ack=1 SHALL capture mem_rdata into ir_out, drive pc_next=latched PC+2 (modulo 2^16, FFFE->0000), pulse pc_we, and enter HOLD.
REQ-026 WAIT SHALL count cycles; if MEM_TIMEOUT cycles elapse without mem_ack, it SHALL pulse fault_bus, return to IDLE, and leave ir_out and pc unchanged.
REQ-027 HOLD SHALL assert ir_valid with ir_out stable until ir_ready=1; ir_valid SHALL then deassert on the next cycle.
REQ-028 HOLD with ir_ready=1, start=1 and sleep=0 SHALL accept the new fetch in the same cycle (back-to-back, REQ-020..023 apply).
REQ-029 Minimum latency: start at cycle 0, mem_rd at cycle 1, ack at cycle 2, ir_valid and pc_we at cycle 3.
REQ-030 Sleep rising during REQ/WAIT/HOLD SHALL NOT abort the in-flight fetch.
REQ-031 start while busy (other than REQ-028) SHALL be ignored.
REQ-032 mem_ack outside WAIT SHALL be ignored.

Reset
REQ-033 Reset=1 SHALL force IDLE, clear the timeout count, and drive all outputs to 0 (mem_addr, ir_out, pc_next = 16'h0000) on the next edge, including mid-fetch.
REQ-034 A mem_ack arriving in the cycle after Reset deasserts SHALL be ignored.
REQ-035 Reset SHALL dominate start in the same cycle.

Structure
REQ-036 The state encoding, FETCH_STEP=2, and the MEM_TIMEOUT default SHALL live in the shared package xm23_pkg.
REQ-037 The timeout counter SHALL be a sub-module fetch_timer (clear, enable, expired).

Verification
REQ-038 pc_in=0100, start, ack 1 cycle after mem_rd, data=4C8A -> mem_addr=0100, ir_out=4C8A, pc_next=0102, pc_we single pulse, ir_valid at cycle 3.
REQ-039 pc_in=00F6=bkpnt, start -> bkpt_hit pulse, mem_rd never asserted; pc_in=0103, start -> fault_odd pulse, no read.
REQ-040 No mem_ack, MEM_TIMEOUT=15 -> fault_bus exactly 15 cycles after WAIT entry, then IDLE; ir_out unchanged.
REQ-041 pc_in=FFFE fetch -> pc_next=0000; hold ir_ready=0 for 5 cycles -> ir_valid and ir_out stable; ir_ready plus start at pc 0000 -> back-to-back fetch.
REQ-042 Reset during WAIT, then ack the next cycle -> outputs 0, IDLE, ack ignored; start with sleep=1 -> no activity.
